// File: rtl/sram_serial_loader.sv
// Serial SRAM loader: samples an asynchronous sclk/sdata pair while the load
// pin holds a window open. It decodes a {sel, addr} header and then writes
// data bytes into successive byte lanes of the 16-bit SRAM words.
// Optional feature macro: LOADER_CHECKSUM_EN adds a running XOR checksum output.
module sram_serial_loader #(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_in,
    input  logic              sclk_in,
    input  logic              sdata_in,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    output logic              sram_sel,
    output logic              sram_we,
    output logic              load_active,
    output logic [ADDR_W+1:0] byte_count,
    output logic              wrapped
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int HDR_BITS = ADDR_W + 1;
    localparam int CNT_W    = $clog2(HDR_BITS + 1);

    localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
    localparam logic [CNT_W-1:0]  HDR_LAST = CNT_W'(HDR_BITS - 1);
    localparam logic [CNT_W-1:0]  BYTE_LAST = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W+1:0] BC_ONE   = 1;

    typedef enum logic [1:0] {IDLE, HDR, DATA, ADV} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] sdata_sync;
    logic [SYNC_STAGES-1:0] load_sync;
    logic                   sclk_prev;
    logic [HDR_BITS-1:0]    shift_reg;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   pending;
    logic                   pending_bit;

    logic sclk_s;
    logic sdata_s;
    logic load_s;
    logic sclk_rise;
    logic data_edge;
    logic data_bit;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign sdata_s   = sdata_sync[SYNC_STAGES-1];
    assign load_s    = load_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;

    // A serial edge parked during ADV is replayed as the next data edge
    always_comb begin
        data_edge = sclk_rise | pending;
        data_bit  = pending ? pending_bit : sdata_s;
    end

    // Bring the three host pins into the clk domain and remember the last sclk level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync  <= '0;
            sdata_sync <= '0;
            load_sync  <= '0;
            sclk_prev  <= 1'b0;
        end else begin
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
            sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], sdata_in};
            load_sync  <= {load_sync[SYNC_STAGES-2:0], load_in};
            sclk_prev  <= sclk_s;
        end
    end

    // Loader FSM: header decode, byte deserialisation, write strobe and lane advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            pending     <= 1'b0;
            pending_bit <= 1'b0;
            sram_addr   <= '0;
            sram_din    <= '0;
            sram_sel    <= 1'b0;
            sram_we     <= 1'b0;
            load_active <= 1'b0;
            byte_count  <= '0;
            wrapped     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            checksum    <= '0;
`endif
        end else begin
            sram_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_s) begin
                        state       <= HDR;
                        load_active <= 1'b1;
                        bit_cnt     <= '0;
                        shift_reg   <= '0;
                        pending     <= 1'b0;
                        wrapped     <= 1'b0;
                        byte_count  <= '0;
`ifdef LOADER_CHECKSUM_EN
                        checksum    <= '0;
`endif
                    end
                end
                HDR: begin
                    if (!load_s) begin
                        state       <= IDLE;
                        load_active <= 1'b0;
                    end else if (sclk_rise) begin
                        shift_reg <= {shift_reg[HDR_BITS-2:0], sdata_s};
                        if (bit_cnt == HDR_LAST) begin
                            sram_sel  <= shift_reg[HDR_BITS-2];
                            sram_addr <= {shift_reg[ADDR_W-2:0], sdata_s};
                            bit_cnt   <= '0;
                            state     <= DATA;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_ONE;
                        end
                    end
                end
                DATA: begin
                    if (!load_s) begin
                        state       <= IDLE;
                        load_active <= 1'b0;
                        pending     <= 1'b0;
                    end else if (data_edge) begin
                        pending   <= 1'b0;
                        shift_reg <= {shift_reg[HDR_BITS-2:0], data_bit};
                        if (bit_cnt == BYTE_LAST) begin
                            sram_din   <= {shift_reg[DATA_W-2:0], data_bit};
                            sram_we    <= 1'b1;
                            byte_count <= byte_count + BC_ONE;
                            bit_cnt    <= '0;
                            state      <= ADV;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_ONE;
                        end
                    end
                end
                ADV: begin
`ifdef LOADER_CHECKSUM_EN
                    checksum <= checksum ^ sram_din;
`endif
                    if (!load_s) begin
                        state       <= IDLE;
                        load_active <= 1'b0;
                        pending     <= 1'b0;
                    end else begin
                        if (sclk_rise) begin
                            pending     <= 1'b1;
                            pending_bit <= sdata_s;
                        end
                        if (!sram_sel) begin
                            sram_sel <= 1'b1;
                        end else begin
                            sram_sel  <= 1'b0;
                            sram_addr <= sram_addr + ADDR_ONE;
                            if (sram_addr == '1) begin
                                wrapped <= 1'b1;
                            end
                        end
                        state <= DATA;
                    end
                end
                default: begin
                    state       <= IDLE;
                    load_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_serial_loader.sv
// Directed testbench for sram_serial_loader: drives the host serial protocol
// at the minimum legal half-period and checks every SRAM write against
// hand-computed expectations. Define LOADER_CHECKSUM_EN to also test the checksum.
module tb_sram_serial_loader;

    localparam int S  = 2;
    localparam int HP = S + 2;

    logic        clk;
    logic        rst;
    logic        load_in;
    logic        sclk_in;
    logic        sdata_in;
    logic [10:0] sram_addr;
    logic [7:0]  sram_din;
    logic        sram_sel;
    logic        sram_we;
    logic        load_active;
    logic [12:0] byte_count;
    logic        wrapped;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  checksum;
`endif

    int n_cmp;
    int n_fail;
    int we_long;
    logic we_prev;

    logic [10:0] qa[$];
    logic        qs[$];
    logic [7:0]  qd[$];

    sram_serial_loader #(
        .ADDR_W(11),
        .DATA_W(8),
        .SYNC_STAGES(S)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load_in(load_in),
        .sclk_in(sclk_in),
        .sdata_in(sdata_in),
        .sram_addr(sram_addr),
        .sram_din(sram_din),
        .sram_sel(sram_sel),
        .sram_we(sram_we),
        .load_active(load_active),
        .byte_count(byte_count),
        .wrapped(wrapped)
`ifdef LOADER_CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write strobe and flag strobes that last more than one cycle
    always @(negedge clk) begin
        if (sram_we) begin
            qa.push_back(sram_addr);
            qs.push_back(sram_sel);
            qd.push_back(sram_din);
            if (we_prev) we_long <= we_long + 1;
        end
        we_prev <= sram_we;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        qa.delete();
        qs.delete();
        qd.delete();
    endtask

    task automatic send_bit(input logic b);
        sdata_in = b;
        sclk_in  = 1'b0;
        cycles(HP);
        sclk_in  = 1'b1;
        cycles(HP);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_header(input logic sel, input logic [10:0] addr);
        logic [11:0] h;
        h = {sel, addr};
        for (int i = 11; i >= 0; i--) send_bit(h[i]);
    endtask

    task automatic open_window();
        sclk_in = 1'b0;
        load_in = 1'b1;
        cycles(S + 2);
    endtask

    task automatic close_window();
        sclk_in = 1'b0;
        load_in = 1'b0;
        cycles(S + 4);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        load_in = 1'b0;
        sclk_in = 1'b0;
        sdata_in = 1'b0;
        cycles(3);
        n_cmp++; if (sram_addr !== 11'h000) begin n_fail++; $display("[TB] FAIL reset_addr: got %h expected 000", sram_addr); end
        n_cmp++; if (sram_din !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_din: got %h expected 00", sram_din); end
        n_cmp++; if (sram_sel !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_sel: got %b expected 0", sram_sel); end
        n_cmp++; if (sram_we !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_we: got %b expected 0", sram_we); end
        n_cmp++; if (load_active !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_active: got %b expected 0", load_active); end
        n_cmp++; if (byte_count !== 13'd0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d expected 0", byte_count); end
        n_cmp++; if (wrapped !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wrapped: got %b expected 0", wrapped); end
        rst = 1'b0;
        cycles(3);
        n_cmp++; if (qa.size() !== 0) begin n_fail++; $display("[TB] FAIL reset_no_write: got %0d writes expected 0", qa.size()); end
    endtask

    task automatic test_basic();
        logic [10:0] ea[3];
        logic        es[3];
        logic [7:0]  ed[3];
        ea = '{11'h010, 11'h010, 11'h011};
        es = '{1'b0, 1'b1, 1'b0};
        ed = '{8'hA5, 8'h3C, 8'h77};
        clear_log();
        open_window();
        n_cmp++; if (load_active !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_active: got %b expected 1", load_active); end
        send_header(1'b0, 11'h010);
        send_byte(8'hA5);
        send_byte(8'h3C);
        send_byte(8'h77);
        close_window();
        n_cmp++; if (qa.size() !== 3) begin n_fail++; $display("[TB] FAIL basic_nwrites: got %0d expected 3", qa.size()); end
        for (int i = 0; i < 3 && i < qa.size(); i++) begin
            n_cmp++;
            if (qa[i] !== ea[i] || qs[i] !== es[i] || qd[i] !== ed[i]) begin
                n_fail++;
                $display("[TB] FAIL basic_write%0d: got (%h,%b,%h) expected (%h,%b,%h)", i, qa[i], qs[i], qd[i], ea[i], es[i], ed[i]);
            end
        end
        n_cmp++; if (byte_count !== 13'd3) begin n_fail++; $display("[TB] FAIL basic_count: got %0d expected 3", byte_count); end
        n_cmp++; if (wrapped !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_wrapped: got %b expected 0", wrapped); end
        n_cmp++; if (load_active !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_closed: got %b expected 0", load_active); end
        n_cmp++; if (we_long !== 0) begin n_fail++; $display("[TB] FAIL basic_we_width: got %0d long strobes expected 0", we_long); end
    endtask

    task automatic test_wrap();
        clear_log();
        open_window();
        send_header(1'b1, 11'h7FF);
        send_byte(8'h11);
        n_cmp++; if (wrapped !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_flag: got %b expected 1", wrapped); end
        n_cmp++; if (sram_addr !== 11'h000 || sram_sel !== 1'b0) begin n_fail++; $display("[TB] FAIL wrap_advance: got (%h,%b) expected (000,0)", sram_addr, sram_sel); end
        send_byte(8'h22);
        close_window();
        n_cmp++; if (qa.size() !== 2) begin n_fail++; $display("[TB] FAIL wrap_nwrites: got %0d expected 2", qa.size()); end
        if (qa.size() == 2) begin
            n_cmp++; if (qa[0] !== 11'h7FF || qs[0] !== 1'b1 || qd[0] !== 8'h11) begin n_fail++; $display("[TB] FAIL wrap_write0: got (%h,%b,%h) expected (7ff,1,11)", qa[0], qs[0], qd[0]); end
            n_cmp++; if (qa[1] !== 11'h000 || qs[1] !== 1'b0 || qd[1] !== 8'h22) begin n_fail++; $display("[TB] FAIL wrap_write1: got (%h,%b,%h) expected (000,0,22)", qa[1], qs[1], qd[1]); end
        end
        n_cmp++; if (wrapped !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_held: got %b expected 1", wrapped); end
        n_cmp++; if (byte_count !== 13'd2) begin n_fail++; $display("[TB] FAIL wrap_count: got %0d expected 2", byte_count); end
    endtask

    task automatic test_abort();
        int lat;
        logic [4:0] part;
        part = 5'b10110;
        clear_log();
        open_window();
        n_cmp++; if (wrapped !== 1'b0 || byte_count !== 13'd0) begin n_fail++; $display("[TB] FAIL abort_open_clear: got (%b,%0d) expected (0,0)", wrapped, byte_count); end
        send_header(1'b0, 11'h100);
        send_byte(8'h5A);
        for (int i = 4; i >= 0; i--) send_bit(part[i]);
        load_in = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            cycles(1);
            if (!load_active) begin
                lat = k;
                break;
            end
        end
        n_cmp++; if (lat !== S + 1) begin n_fail++; $display("[TB] FAIL abort_latency: got %0d expected %0d", lat, S + 1); end
        sclk_in = 1'b0;
        cycles(HP);
        n_cmp++; if (qa.size() !== 1) begin n_fail++; $display("[TB] FAIL abort_nwrites: got %0d expected 1", qa.size()); end
        if (qa.size() >= 1) begin
            n_cmp++; if (qa[0] !== 11'h100 || qs[0] !== 1'b0 || qd[0] !== 8'h5A) begin n_fail++; $display("[TB] FAIL abort_write0: got (%h,%b,%h) expected (100,0,5a)", qa[0], qs[0], qd[0]); end
        end
        n_cmp++; if (byte_count !== 13'd1) begin n_fail++; $display("[TB] FAIL abort_count: got %0d expected 1", byte_count); end
        n_cmp++; if (sram_addr !== 11'h100 || sram_sel !== 1'b1 || sram_din !== 8'h5A) begin n_fail++; $display("[TB] FAIL abort_hold: got (%h,%b,%h) expected (100,1,5a)", sram_addr, sram_sel, sram_din); end
    endtask

    task automatic test_reset_mid();
        clear_log();
        open_window();
        send_header(1'b1, 11'h055);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        sdata_in = 1'b1;
        sclk_in  = 1'b1;
        rst = 1'b1;
        #1;
        n_cmp++; if (sram_addr !== 11'h000 || sram_sel !== 1'b0 || sram_din !== 8'h00) begin n_fail++; $display("[TB] FAIL rstmid_data: got (%h,%b,%h) expected (000,0,00)", sram_addr, sram_sel, sram_din); end
        n_cmp++; if (load_active !== 1'b0 || sram_we !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_ctrl: got (%b,%b) expected (0,0)", load_active, sram_we); end
        n_cmp++; if (byte_count !== 13'd0 || wrapped !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_count: got (%0d,%b) expected (0,0)", byte_count, wrapped); end
        load_in = 1'b0;
        sclk_in = 1'b0;
        cycles(4);
        rst = 1'b0;
        cycles(8);
        n_cmp++; if (qa.size() !== 0) begin n_fail++; $display("[TB] FAIL rstmid_spurious: got %0d writes expected 0", qa.size()); end
        open_window();
        send_header(1'b0, 11'h020);
        send_byte(8'hC3);
        close_window();
        n_cmp++; if (qa.size() !== 1) begin n_fail++; $display("[TB] FAIL rstmid_nwrites: got %0d expected 1", qa.size()); end
        if (qa.size() >= 1) begin
            n_cmp++; if (qa[0] !== 11'h020 || qs[0] !== 1'b0 || qd[0] !== 8'hC3) begin n_fail++; $display("[TB] FAIL rstmid_write0: got (%h,%b,%h) expected (020,0,c3)", qa[0], qs[0], qd[0]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] ea;
        logic        es;
        logic [7:0]  ed;
        clear_log();
        open_window();
        send_header(1'b0, 11'h400);
        for (int i = 0; i < 64; i++) send_byte(8'((i * 7) + 3));
        close_window();
        n_cmp++; if (qa.size() !== 64) begin n_fail++; $display("[TB] FAIL b2b_nwrites: got %0d expected 64", qa.size()); end
        for (int i = 0; i < 64 && i < qa.size(); i++) begin
            ea = 11'h400 + 11'(i / 2);
            es = 1'(i % 2);
            ed = 8'((i * 7) + 3);
            n_cmp++;
            if (qa[i] !== ea || qs[i] !== es || qd[i] !== ed) begin
                n_fail++;
                $display("[TB] FAIL b2b_write%0d: got (%h,%b,%h) expected (%h,%b,%h)", i, qa[i], qs[i], qd[i], ea, es, ed);
            end
        end
        n_cmp++; if (byte_count !== 13'd64) begin n_fail++; $display("[TB] FAIL b2b_count: got %0d expected 64", byte_count); end
        n_cmp++; if (we_long !== 0) begin n_fail++; $display("[TB] FAIL b2b_we_width: got %0d long strobes expected 0", we_long); end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        clear_log();
        open_window();
        send_header(1'b0, 11'h300);
        send_byte(8'h0F);
        send_byte(8'hF0);
        send_byte(8'hAA);
        n_cmp++; if (checksum !== 8'h55) begin n_fail++; $display("[TB] FAIL csum_value: got %h expected 55", checksum); end
        close_window();
        n_cmp++; if (checksum !== 8'h55) begin n_fail++; $display("[TB] FAIL csum_held: got %h expected 55", checksum); end
        open_window();
        n_cmp++; if (checksum !== 8'h00) begin n_fail++; $display("[TB] FAIL csum_clear: got %h expected 00", checksum); end
        close_window();
    endtask
`endif

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        we_long = 0;
        we_prev = 1'b0;
        rst      = 1'b1;
        load_in  = 1'b0;
        sclk_in  = 1'b0;
        sdata_in = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_abort();
        test_reset_mid();
        test_back_to_back();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
